psram_ddr_responder: RTL and testbench

PSRAM_DDR_RESPONDER -- requirements
Module: psram_ddr_responder

---
 rtl/psram_ddr_responder.sv | 155 +++++++++++++++
 tb/tb_psram_ddr_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/psram_ddr_responder.sv
// DDR PSRAM-style target: 3-beat CA phase, fixed access latency, linear read/write bursts,
// plus a register space (one config register for writes, a fixed ID for reads).
module psram_ddr_responder #(
  parameter int          LATENCY = 6,
  parameter int          ADDR_W  = 6,
  parameter logic [15:0] REG_ID  = 16'h0C81
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_n,
  input  logic [15:0] dq_in,
  input  logic [1:0]  rwds_in,
  output logic [15:0] dq_out,
  output logic [7:0]  dq_oe,
  output logic [1:0]  rwds_out,
  output logic        rwds_oe,
  output logic [15:0] cfg_reg,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, CA, LAT, WDATA, RDATA, REGW} state_t;

  localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic              reg_q, reg_d;
  logic [ADDR_W-4:0] ca_mid_q, ca_mid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       dq_out_q, dq_out_d;
  logic [15:0]       cfg_q, cfg_d;
  logic [7:0]        dq_oe_q, dq_oe_d;
  logic [1:0]        rwds_out_q, rwds_out_d;
  logic              rwds_oe_q, rwds_oe_d;
  logic              mem_we;
  logic [1:0]        mem_be;

  logic [15:0] mem_q [2**ADDR_W];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    reg_d    = reg_q;
    ca_mid_d = ca_mid_q;
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    cfg_d    = cfg_q;
    mem_we   = 1'b0;
    mem_be   = 2'b00;
    // cs_n high in any active state drops the transaction
    if (state_q != IDLE && cs_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!cs_n) begin
            state_d = CA;
            rd_d    = dq_in[15];
            reg_d   = dq_in[14];
            cnt_d   = 4'd0;
          end
        end
        CA: begin
          if (cnt_q == 4'd0) begin
            ca_mid_d = dq_in[ADDR_W-4:0];
            cnt_d    = 4'd1;
          end else begin
            addr_d  = {ca_mid_q, dq_in[2:0]};
            cnt_d   = 4'd0;
            state_d = (reg_q && !rd_q) ? REGW : LAT;
          end
        end
        LAT: begin
          if (cnt_q == LAT_LAST) begin
            if (rd_q) begin
              // first read word is registered here so it is valid for the whole first data cycle
              state_d  = RDATA;
              dq_out_d = reg_q ? REG_ID : mem_q[addr_q];
              addr_d   = addr_q + 1'b1;
            end else begin
              state_d = WDATA;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        WDATA: begin
          mem_we = 1'b1;
          mem_be = ~rwds_in;
          addr_d = addr_q + 1'b1;
        end
        RDATA: begin
          dq_out_d = reg_q ? REG_ID : mem_q[addr_q];
          addr_d   = addr_q + 1'b1;
        end
        REGW: begin
          if (cnt_q == 4'd0) begin
            cfg_d = dq_in;
            cnt_d = 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    dq_oe_d    = (state_d == RDATA) ? 8'hFF : 8'h00;
    rwds_out_d = (state_d == RDATA) ? 2'b10 : 2'b00;
    rwds_oe_d  = (state_d == CA) || (state_d == LAT) || (state_d == RDATA);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rd_q       <= 1'b0;
      reg_q      <= 1'b0;
      ca_mid_q   <= '0;
      addr_q     <= '0;
      dq_out_q   <= 16'h0000;
      cfg_q      <= 16'h8F1F;
      dq_oe_q    <= 8'h00;
      rwds_out_q <= 2'b00;
      rwds_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      reg_q      <= reg_d;
      ca_mid_q   <= ca_mid_d;
      addr_q     <= addr_d;
      dq_out_q   <= dq_out_d;
      cfg_q      <= cfg_d;
      dq_oe_q    <= dq_oe_d;
      rwds_out_q <= rwds_out_d;
      rwds_oe_q  <= rwds_oe_d;
    end
  end

  // storage deliberately has no reset so contents survive rst
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (mem_be[1]) mem_q[addr_q][15:8] <= dq_in[15:8];
      if (mem_be[0]) mem_q[addr_q][7:0]  <= dq_in[7:0];
    end
  end

  assign dq_out   = dq_out_q;
  assign dq_oe    = dq_oe_q;
  assign rwds_out = rwds_out_q;
  assign rwds_oe  = rwds_oe_q;
  assign cfg_reg  = cfg_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_psram_ddr_responder.sv
// Randomised bench for psram_ddr_responder: read beats go through a scoreboard fed from a word-array model.
module tb_psram_ddr_responder;
  localparam int LATENCY = 6;
  localparam int ADDR_W  = 6;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam logic [15:0] REG_ID = 16'h0C81;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n;
  logic [15:0] dq_in;
  logic [1:0]  rwds_in;
  logic [15:0] dq_out;
  logic [7:0]  dq_oe;
  logic [1:0]  rwds_out;
  logic        rwds_oe;
  logic [15:0] cfg_reg;
  logic        busy;

  psram_ddr_responder #(.LATENCY(LATENCY), .ADDR_W(ADDR_W), .REG_ID(REG_ID)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .dq_in(dq_in), .rwds_in(rwds_in),
    .dq_out(dq_out), .dq_oe(dq_oe), .rwds_out(rwds_out), .rwds_oe(rwds_oe),
    .cfg_reg(cfg_reg), .busy(busy)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] wr_d[$];
  logic [1:0]  wr_m[$];
  logic [15:0] model_mem [DEPTH];
  logic [15:0] model_cfg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // CA words carry random junk in the bits the responder must ignore
  task automatic send_ca(input logic rd, input logic rg, input int addr);
    logic [15:0] hi, mid, lo;
    hi  = {rd, rg, 14'($urandom)};
    mid = (16'($urandom) & 16'hFFF8) | 16'((addr >> 3) & 7);
    lo  = (16'($urandom) & 16'hFFF8) | 16'(addr & 7);
    cs_n = 1'b0; dq_in = hi;  step();
    dq_in = mid; step();
    dq_in = lo;  step();
  endtask

  task automatic end_txn();
    cs_n = 1'b1; rwds_in = 2'b00; step();
    chk("busy_after_cs_rise", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_write(input int addr);
    int a;
    send_ca(1'b0, 1'b0, addr);
    chk("lat_rwds_oe", {31'd0, rwds_oe}, 32'd1);
    chk("lat_oe_rwds", {22'd0, dq_oe, rwds_out}, 32'd0);
    repeat (LATENCY) step();
    a = addr;
    for (int i = 0; i < wr_d.size(); i++) begin
      dq_in = wr_d[i]; rwds_in = wr_m[i];
      step();
      if (i == 0) chk("wdata_rwds_oe", {31'd0, rwds_oe}, 32'd0);
      if (!wr_m[i][1]) model_mem[a][15:8] = wr_d[i][15:8];
      if (!wr_m[i][0]) model_mem[a][7:0]  = wr_d[i][7:0];
      a = (a + 1) % DEPTH;
    end
    end_txn();
  endtask

  task automatic do_read(input int addr, input int n, input logic rg);
    for (int i = 0; i < n; i++)
      exp_q.push_back(rg ? REG_ID : model_mem[(addr + i) % DEPTH]);
    send_ca(1'b1, rg, addr);
    repeat (LATENCY) step();
    repeat (n - 1) step();
    end_txn();
  endtask

  task automatic do_regw(input logic [15:0] d, input int extra);
    send_ca(1'b0, 1'b1, $urandom_range(0, DEPTH - 1));
    dq_in = d; rwds_in = 2'($urandom);
    step();
    model_cfg = d;
    chk("cfg_no_latency", {16'd0, cfg_reg}, {16'd0, model_cfg});
    repeat (extra) begin dq_in = 16'($urandom); step(); end
    end_txn();
    chk("cfg_after_regw", {16'd0, cfg_reg}, {16'd0, model_cfg});
  endtask

  task automatic set_burst(input int n, input logic rnd_mask);
    wr_d.delete(); wr_m.delete();
    for (int i = 0; i < n; i++) begin
      wr_d.push_back(16'($urandom));
      wr_m.push_back(rnd_mask ? 2'($urandom) : 2'b00);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && dq_oe === 8'hFF) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_read_beat actual=%h expected=none at %0t", dq_out, $time);
      end else begin
        chk("read_beat", {16'd0, dq_out}, {16'd0, exp_q.pop_front()});
        chk("read_rwds", {29'd0, rwds_oe, rwds_out}, {29'd0, 1'b1, 2'b10});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cs_n = 1'b1; dq_in = 16'h0; rwds_in = 2'b00;
    model_cfg = 16'h8F1F;
    foreach (model_mem[i]) model_mem[i] = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {dq_out, dq_oe, rwds_out, rwds_oe, busy}, 32'd0);
    chk("reset_cfg", {16'd0, cfg_reg}, 32'h8F1F);
    rst = 1'b0;
    step();

    // fill the whole array so later reads are fully known
    set_burst(DEPTH, 1'b0);
    do_write(0);
    do_read(0, 8, 1'b0);

    wr_d = '{16'hA1A2, 16'hB1B2}; wr_m = '{2'b00, 2'b00};
    do_write(2);
    do_read(2, 2, 1'b0);

    wr_d = '{16'h5566}; wr_m = '{2'b01};
    do_write(2);
    do_read(2, 1, 1'b0);

    do_regw(16'h8F17, 2);
    do_read(0, 3, 1'b1);

    do_read(DEPTH - 1, 3, 1'b0);

    // abort at C1, then a partial register-write CA aborted at C2
    cs_n = 1'b0; dq_in = 16'h6000; step();
    cs_n = 1'b1; step();
    chk("abort_c1_idle", {31'd0, busy}, 32'd0);
    cs_n = 1'b0; dq_in = 16'h6000; step();
    dq_in = 16'h0000; step();
    cs_n = 1'b1; dq_in = 16'h1234; step();
    chk("abort_c2_idle", {31'd0, busy}, 32'd0);
    chk("abort_c2_cfg", {16'd0, cfg_reg}, {16'd0, model_cfg});
    // new CA right after the abort edge; also a write aborted inside LAT
    do_read(5, 2, 1'b0);
    send_ca(1'b0, 1'b0, 20);
    repeat (2) step();
    cs_n = 1'b1; dq_in = 16'hDEAD; step();
    do_read(20, 2, 1'b0);

    // reset in the middle of a write burst: two beats land, the third does not
    send_ca(1'b0, 1'b0, 10);
    repeat (LATENCY) step();
    for (int i = 0; i < 2; i++) begin
      dq_in = 16'hC0C0 + 16'(i); rwds_in = 2'b00; step();
      model_mem[10 + i] = 16'hC0C0 + 16'(i);
    end
    dq_in = 16'hEEEE;
    #2 rst = 1'b1;
    #1;
    chk("midrst_outputs", {dq_out, dq_oe, rwds_out, rwds_oe, busy}, 32'd0);
    chk("midrst_cfg", {16'd0, cfg_reg}, 32'h8F1F);
    model_cfg = 16'h8F1F;
    cs_n = 1'b1;
    step();
    rst = 1'b0;
    step();
    do_read(9, 4, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int kind, addr, n;
      kind = $urandom_range(0, 3);
      addr = $urandom_range(0, DEPTH - 1);
      n    = $urandom_range(1, 6);
      case (kind)
        0: begin set_burst(n, 1'b1); do_write(addr); end
        1: do_read(addr, n, 1'b0);
        2: do_regw(16'($urandom), $urandom_range(0, 2));
        default: do_read(addr, n, 1'b1);
      endcase
    end
    do_read(0, DEPTH, 1'b0);

    repeat (3) step();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
